// File: rtl/sequence_serializer.sv
// Parallel-to-serial front end for the sequence detector: takes a word over valid/ready
// and shifts it out one bit per clock. Define SEQUENCE_SERIALIZER_PARITY_EN to append an even-parity bit.
module sequence_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done
);

`ifdef SEQUENCE_SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_serial_out;
    logic             r_serial_valid;
    logic             r_frame_done;
    logic             r_data_ready;

    logic             w_xfer;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_load_bit;
    logic [WIDTH-1:0] w_load_shift;
    logic             w_shift_bit;
    logic [WIDTH-1:0] w_adv_shift;
    logic             w_adv_bit;

    assign w_xfer    = data_valid && r_data_ready;
    assign w_cnt_inc = r_cnt + CW'(1);

    // The first bit goes straight to the output at capture; the register keeps the rest.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_load_bit   = data_in[WIDTH-1];
            assign w_load_shift = {data_in[WIDTH-2:0], 1'b0};
            assign w_shift_bit  = r_shift[WIDTH-1];
            assign w_adv_shift  = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign w_load_bit   = data_in[0];
            assign w_load_shift = {1'b0, data_in[WIDTH-1:1]};
            assign w_shift_bit  = r_shift[0];
            assign w_adv_shift  = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

`ifdef SEQUENCE_SERIALIZER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_xfer) begin
            r_parity <= ^data_in;
        end
    end

    assign w_adv_bit = (w_cnt_inc == CW'(WIDTH)) ? r_parity : w_shift_bit;
`else
    assign w_adv_bit = w_shift_bit;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_shift        <= '0;
            r_cnt          <= '0;
            r_serial_out   <= IDLE_LEVEL;
            r_serial_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_data_ready   <= 1'b1;
        end else if (w_xfer) begin
            // Capture is only possible in IDLE or on the last bit, so this also covers back-to-back frames.
            r_state        <= ST_SHIFT;
            r_shift        <= w_load_shift;
            r_cnt          <= '0;
            r_serial_out   <= w_load_bit;
            r_serial_valid <= 1'b1;
            r_frame_done   <= 1'b0;
            r_data_ready   <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            if (r_cnt == LAST_CNT) begin
                r_state        <= ST_IDLE;
                r_cnt          <= '0;
                r_serial_out   <= IDLE_LEVEL;
                r_serial_valid <= 1'b0;
                r_frame_done   <= 1'b0;
                r_data_ready   <= 1'b1;
            end else begin
                r_shift        <= w_adv_shift;
                r_cnt          <= w_cnt_inc;
                r_serial_out   <= w_adv_bit;
                r_serial_valid <= 1'b1;
                r_frame_done   <= (w_cnt_inc == LAST_CNT);
                r_data_ready   <= (w_cnt_inc == LAST_CNT);
            end
        end
    end

    assign data_ready   = r_data_ready;
    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_sequence_serializer.sv
// Drives an MSB-first/idle-0 instance and an LSB-first/idle-1 instance with the same stimulus
// and compares every cycle against per-instance queues of bits still to be sent.
module tb_sequence_serializer;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready0, sout0, svalid0, done0;
    logic       ready1, sout1, svalid1, done1;

    int checks = 0;
    int errors = 0;

    bit q0[$];
    bit q1[$];

    sequence_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut0 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready0), .serial_out(sout0), .serial_valid(svalid0), .frame_done(done0)
    );

    sequence_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut1 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready1), .serial_out(sout1), .serial_valid(svalid1), .frame_done(done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from what is still queued for each instance.
    task automatic check_outputs(input string tag);
        check({tag, " dut0 serial_out"},   sout0,   (q0.size() > 0) ? q0[0] : 1'b0);
        check({tag, " dut0 serial_valid"}, svalid0, q0.size() > 0);
        check({tag, " dut0 frame_done"},   done0,   q0.size() == 1);
        check({tag, " dut0 data_ready"},   ready0,  q0.size() <= 1);
        check({tag, " dut1 serial_out"},   sout1,   (q1.size() > 0) ? q1[0] : 1'b1);
        check({tag, " dut1 serial_valid"}, svalid1, q1.size() > 0);
        check({tag, " dut1 frame_done"},   done1,   q1.size() == 1);
        check({tag, " dut1 data_ready"},   ready1,  q1.size() <= 1);
    endtask

    // One clock: drive inputs, let the edge happen, update the model, then check.
    task automatic cycle(input logic v, input logic [7:0] d, input string tag, output bit accepted);
        bit was_ready;
        data_valid = v;
        data_in    = d;
        was_ready  = (q0.size() <= 1);
        @(posedge clock);
        accepted = v && was_ready;
        if (q0.size() > 0) void'(q0.pop_front());
        if (q1.size() > 0) void'(q1.pop_front());
        if (accepted) begin
            for (int k = 0; k < 8; k++) begin
                q0.push_back(d[7-k]);
                q1.push_back(d[k]);
            end
`ifdef SEQUENCE_SERIALIZER_PARITY_EN
            q0.push_back(^d);
            q1.push_back(^d);
`endif
        end
        #1;
        check_outputs(tag);
        $display("cycle t=%0t valid=%0b data=%02h accepted=%0b out0=%0b out1=%0b done0=%0b",
                 $time, v, d, accepted, sout0, sout1, done0);
    endtask

    // Holds data_valid until the word is taken; garbage on data_in afterwards must be ignored.
    task automatic send_word(input logic [7:0] d, input string tag);
        bit acc;
        int budget;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 20) begin
            cycle(1'b1, d, tag, acc);
            budget++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $error("FAIL %s handshake observed none expected within 20 cycles", tag);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), tag, acc);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " dut0 serial_out"},   sout0,   1'b0);
        check({tag, " dut0 serial_valid"}, svalid0, 1'b0);
        check({tag, " dut0 frame_done"},   done0,   1'b0);
        check({tag, " dut0 data_ready"},   ready0,  1'b1);
        check({tag, " dut1 serial_out"},   sout1,   1'b1);
        check({tag, " dut1 serial_valid"}, svalid1, 1'b0);
        check({tag, " dut1 frame_done"},   done1,   1'b0);
        check({tag, " dut1 data_ready"},   ready1,  1'b1);
    endtask

    task automatic async_reset(input string tag);
        #3;
        reset      = 1'b1;
        data_valid = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check_reset_values({tag, " immediate"});
        @(posedge clock);
        #1;
        check_reset_values({tag, " held"});
        #3;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        bit acc;
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;

        #2;
        check_reset_values("reset_async_start");
        #28;
        check_reset_values("reset_held_30ns");
        reset = 1'b0;
        @(negedge clock);
        idle_cycles(4, "idle_after_reset");

        send_word(8'hB2, "single_B2");
        idle_cycles(10, "single_B2_drain");

        send_word(8'hB2, "b2b_first_B2");
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'h0F, "b2b_wait", acc);
        send_word(8'h0F, "b2b_second_0F");
        idle_cycles(10, "b2b_drain");

        send_word(8'hFF, "abort_FF");
        idle_cycles(3, "abort_FF_bits");
        async_reset("midframe_reset");
        send_word(8'h81, "after_reset_81");
        idle_cycles(10, "after_reset_drain");

        send_word(8'h01, "word_01");
        idle_cycles(10, "word_01_drain");

        send_word(8'h07, "word_07");
        idle_cycles(10, "word_07_drain");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 4), "rand_gap");
            send_word(8'($urandom), "rand_word");
            if (n == 30) begin
                idle_cycles($urandom_range(0, 6), "rand_prereset");
                async_reset("rand_reset");
            end
        end
        idle_cycles(12, "final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
